// File: rtl/cos_pkg.sv
// Shared definitions for the cosine job dispatcher: operand/result widths,
// the dispatcher state enumeration and the queued job record.
package cos_pkg;

  localparam int X_W   = 16;
  localparam int Y_W   = 8;
  localparam int ANS_W = 16;
  localparam int JOB_W = X_W + Y_W;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_CLR,
    WAIT_DONE,
    HOLD
  } state_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } job_t;

endpackage

// File: rtl/cos_job_fifo.sv
// Job queue between the upstream handshake and the dispatcher FSM.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   wr_en, wr_data  push one job (ignored while full)
//   rd_en, rd_data  pop the head job; rd_data always shows the head
//   full, empty     occupancy flags
module cos_job_fifo
  import cos_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_en,
  input  job_t wr_data,
  input  logic rd_en,
  output job_t rd_data,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the index bits match.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  job_t        mem [DEPTH];

  logic do_wr;
  logic do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // NOTE: the storage array is deliberately not reset; validity is defined
  // solely by the pointers, so clearing the entries would only cost logic.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/cos_job_dispatcher.sv
// Queues (x, y) jobs, feeds them one at a time to a multi-cycle cosine unit,
// and presents each result (or a timeout error) through a valid/ready port.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   in_valid/in_ready/in_x/in_y    upstream job handshake
//   cos_start/cos_x/cos_y          start pulse and held operands to the unit
//   cos_ans/cos_ans_ready          unit result and done indication
//   out_valid/out_ready            downstream result handshake
//   out_ans/out_err                result value; out_err marks a timeout
//   busy                           FSM is not idle
module cos_job_dispatcher
  import cos_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [X_W-1:0]   in_x,
  input  logic [Y_W-1:0]   in_y,
  output logic             cos_start,
  output logic [X_W-1:0]   cos_x,
  output logic [Y_W-1:0]   cos_y,
  input  logic [ANS_W-1:0] cos_ans,
  input  logic             cos_ans_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ANS_W-1:0] out_ans,
  output logic             out_err,
  output logic             busy
);

  localparam int               CNT_W   = $clog2(TIMEOUT + 1);
  // Abort fires during the TIMEOUT-th cycle spent waiting after the start.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] to_cnt;

  job_t in_job;
  job_t head;
  logic fifo_full;
  logic fifo_empty;

  logic pop;
  logic capture;
  logic abort;
  logic result_free;

  assign in_job   = '{x: in_x, y: in_y};
  assign in_ready = !fifo_full;

  cos_job_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_valid && in_ready),
    .wr_data (in_job),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // A new job may only start once the result register is free (or being
  // emptied this cycle), so an unconsumed result is never overwritten.
  assign result_free = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    abort     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty && result_free) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT_CLR;
      WAIT_CLR: begin
        // A done level left over from the previous job must drop first.
        if (to_cnt == TO_LAST) begin
          abort     = 1'b1;
          state_nxt = HOLD;
        end else if (!cos_ans_ready) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // A real done in the last allowed cycle still wins over the abort.
        if (cos_ans_ready) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end else if (to_cnt == TO_LAST) begin
          abort     = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        // A late done for the aborted job is swallowed here.
        if (!cos_ans_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cos_start = (state == ISSUE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (state == ISSUE) begin
      to_cnt <= '0;
    end else if (state == WAIT_CLR || state == WAIT_DONE) begin
      to_cnt <= to_cnt + CNT_W'(1);
    end
  end

  // Operands are loaded only on pop, so they stay frozen for the whole job.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cos_x <= '0;
      cos_y <= '0;
    end else if (pop) begin
      cos_x <= head.x;
      cos_y <= head.y;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_ans   <= '0;
      out_err   <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_ans   <= cos_ans;
      out_err   <= 1'b0;
    end else if (abort) begin
      out_valid <= 1'b1;
      out_ans   <= '0;
      out_err   <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cos_job_dispatcher.sv
// Self-checking bench for cos_job_dispatcher. A behavioural cosine unit
// answers each start with f(x, y) after a programmable delay; a scoreboard
// queue holds the expected result of every accepted job in acceptance order.
module tb_cos_job_dispatcher;

  localparam int DEPTH       = 4;
  localparam int TIMEOUT     = 255;
  localparam int MODE_PULSE  = 0;
  localparam int MODE_LEVEL  = 1;
  localparam int MODE_SILENT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic [7:0]  in_y;
  logic        cos_start;
  logic [15:0] cos_x;
  logic [7:0]  cos_y;
  logic [15:0] cos_ans;
  logic        cos_ans_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_ans;
  logic        out_err;
  logic        busy;

  cos_job_dispatcher #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_x          (in_x),
    .in_y          (in_y),
    .cos_start     (cos_start),
    .cos_x         (cos_x),
    .cos_y         (cos_y),
    .cos_ans       (cos_ans),
    .cos_ans_ready (cos_ans_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_ans       (out_ans),
    .out_err       (out_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference cosine unit result; chosen so (0x0400, 0x03) gives 0x3A12.
  function automatic logic [15:0] cos_model(input logic [15:0] x, input logic [7:0] y);
    return x ^ {8'h3E, 8'h11 ^ y};
  endfunction

  typedef struct {
    logic [15:0] ans;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_in;
  exp_t e_out;
  logic exp_err_next = 1'b0;

  int          rsp_mode   = MODE_PULSE;
  int          rsp_lat    = 20;
  int          starts     = 0;
  int unsigned last_start = 0;

  logic rand_ready = 1'b0;
  logic ready_set  = 1'b1;

  always @(negedge clk) out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_set;

  // Behavioural cosine unit.
  initial begin
    logic [15:0] jx;
    logic [7:0]  jy;
    int          left;
    int          stale_left;
    bit          pend;
    bit          pulse_off;
    bit          level_hold;
    jx = '0; jy = '0; left = 0; stale_left = 0;
    pend = 0; pulse_off = 0; level_hold = 0;
    cos_ans_ready = 1'b0;
    cos_ans       = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pend = 0; pulse_off = 0; level_hold = 0; stale_left = 0;
        cos_ans_ready = 1'b0;
      end else begin
        if (pulse_off) begin
          cos_ans_ready = 1'b0;
          pulse_off = 0;
        end
        if (level_hold && rsp_mode != MODE_LEVEL) begin
          cos_ans_ready = 1'b0;
          level_hold = 0;
          stale_left = 0;
        end
        if (stale_left > 0) begin
          stale_left--;
          if (stale_left == 0) begin
            cos_ans_ready = 1'b0;
            level_hold = 0;
          end
        end
        if (pend) begin
          left--;
          if (left <= 0) begin
            pend = 0;
            check("cos_x_stable", cos_x, jx);
            check("cos_y_stable", cos_y, jy);
            cos_ans       = cos_model(jx, jy);
            cos_ans_ready = 1'b1;
            if (rsp_mode == MODE_LEVEL) level_hold = 1;
            else                        pulse_off  = 1;
          end
        end
        if (cos_start) begin
          starts++;
          last_start = cyc;
          jx = cos_x;
          jy = cos_y;
          if (rsp_mode != MODE_SILENT) begin
            pend = 1;
            left = rsp_lat;
          end
          // Done from the previous job stays high two more cycles into this one.
          if (level_hold) stale_left = 2;
        end
      end
    end
  end

  // Scoreboard: record accepted jobs, compare every consumed result.
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      if (in_valid && in_ready) begin
        e_in.ans = exp_err_next ? 16'h0000 : cos_model(in_x, in_y);
        e_in.err = exp_err_next;
        exp_q.push_back(e_in);
      end
      if (out_valid && out_ready) begin
        check("sb_has_entry", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e_out = exp_q.pop_front();
          check("sb_out_ans", out_ans, e_out.ans);
          check("sb_out_err", out_err, e_out.err);
        end
      end
    end
  end

  task automatic push(input logic [15:0] x, input logic [7:0] y);
    int n = 0;
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("push_bound", 32'(n < 500), 1);
    @(negedge clk);
  endtask

  task automatic wait_out(input int bound, output int unsigned t);
    int n = 0;
    while (!out_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("wait_out_bound", 32'(n < bound), 1);
    t = cyc;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((exp_q.size() != 0 || busy || out_valid) && n < bound) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("drain_bound", 32'(n < bound), 1);
    @(negedge clk);
  endtask

  initial begin
    int unsigned a;
    int unsigned t;
    int          s;
    in_valid = 1'b0;
    in_x     = '0;
    in_y     = '0;
    rst      = 1'b1;
    #2 rst   = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_cos_start", cos_start, 0);
    check("rst_busy",      busy,      0);
    check("rst_cos_x",     cos_x,     0);
    check("rst_cos_y",     cos_y,     0);
    check("rst_out_ans",   out_ans,   0);
    check("rst_out_err",   out_err,   0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("no_start_after_release", starts, 0);
    check("idle_busy", busy, 0);

    // Single job, done pulse 20 cycles after start: result at acceptance + 23.
    rsp_mode = MODE_PULSE;
    rsp_lat  = 20;
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_x = 16'h0400; in_y = 8'h03;
    a = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(100, t);
    check("latency_single", t, a + 23);
    check("single_ans", out_ans, 16'h3A12);
    check("single_err", out_err, 0);
    drain(100);
    check("single_start_count", starts, 1);

    // Result held unconsumed: no dispatch, FIFO fills to DEPTH, ans stable.
    ready_set = 1'b0;
    rsp_lat   = 6;
    push(16'h1234, 8'h56);
    in_valid = 1'b0;
    wait_out(100, t);
    s = starts;
    for (int i = 0; i < DEPTH; i++) begin
      check("in_ready_before_fill", in_ready, 1);
      push(16'(16'h2000 + i), 8'(i + 1));
    end
    in_valid = 1'b1; in_x = 16'hBEEF; in_y = 8'hA5;
    check("in_ready_full", in_ready, 0);
    repeat (20) @(negedge clk);
    check("no_start_while_held", starts, s);
    check("held_out_valid", out_valid, 1);
    check("held_out_ans", out_ans, cos_model(16'h1234, 8'h56));
    ready_set = 1'b1;
    push(16'hBEEF, 8'hA5);
    in_valid = 1'b0;
    drain(400);
    check("fill_start_count", starts, s + DEPTH + 1);

    // Done level held from the previous job through the next start.
    rsp_mode = MODE_LEVEL;
    rsp_lat  = 8;
    push(16'h0101, 8'h11);
    push(16'h0202, 8'h22);
    push(16'h0303, 8'h33);
    in_valid = 1'b0;
    drain(300);
    rsp_mode = MODE_PULSE;
    repeat (3) @(negedge clk);
    check("level_ready_low", cos_ans_ready, 0);

    // Unit never answers: timeout error after TIMEOUT wait cycles, then recovery.
    rsp_mode     = MODE_SILENT;
    exp_err_next = 1'b1;
    push(16'h7777, 8'h77);
    in_valid     = 1'b0;
    exp_err_next = 1'b0;
    wait_out(TIMEOUT + 100, t);
    check("timeout_latency", t, last_start + TIMEOUT + 1);
    check("timeout_err", out_err, 1);
    check("timeout_ans", out_ans, 0);
    drain(100);
    rsp_mode = MODE_PULSE;
    rsp_lat  = 5;
    push(16'h0F0F, 8'hF0);
    in_valid = 1'b0;
    drain(100);

    // Random traffic with random unit latency and downstream backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      rsp_lat = int'($urandom_range(2, 12));
      push(16'($urandom), 8'($urandom));
    end
    in_valid   = 1'b0;
    rand_ready = 1'b0;
    drain(3000);

    // Reset in the middle of a job with three more queued.
    rsp_lat = 60;
    for (int i = 0; i < 4; i++) push(16'(16'h5000 + i), 8'(8'h40 + i));
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_job_busy", busy, 1);
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("mr_out_valid", out_valid, 0);
    check("mr_busy",      busy,      0);
    check("mr_cos_start", cos_start, 0);
    check("mr_cos_x",     cos_x,     0);
    check("mr_cos_y",     cos_y,     0);
    check("mr_out_ans",   out_ans,   0);
    check("mr_out_err",   out_err,   0);
    check("mr_in_ready",  in_ready,  1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    s   = starts;
    repeat (20) @(negedge clk);
    check("mr_no_start", starts, s);
    check("mr_idle", busy, 0);
    check("mr_no_out", out_valid, 0);
    rsp_lat = 4;
    push(16'h6543, 8'h21);
    in_valid = 1'b0;
    drain(100);
    check("mr_one_start", starts, s + 1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cos_job_dispatcher.md
COS_JOB_DISPATCHER -- requirements
Module: cos_job_dispatcher

Interface
REQ-001 Parameter DEPTH, default 4, job FIFO depth (power of two, >=2).
REQ-002 Parameter TIMEOUT, default 255, max cycles waited for cos_ans_ready before abort.
REQ-003 Port clk  input  1  single clock, rising edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  upstream job offered.
REQ-006 Port in_ready  output  1  FIFO not full; job accepted when in_valid&in_ready.
REQ-007 Port in_x  input  16  job x operand.
REQ-008 Port in_y  input  8  job y operand.
REQ-009 Port cos_start  output  1  one-cycle start pulse to cosine unit.
REQ-010 Port cos_x  output  16  x operand held stable from start until capture.
REQ-011 Port cos_y  output  8  y operand held stable from start until capture.
REQ-012 Port cos_ans  input  16  cosine unit result.
REQ-013 Port cos_ans_ready  input  1  cosine unit done (level or pulse).
REQ-014 Port out_valid  output  1  result register holds a result.
REQ-015 Port out_ready  input  1  downstream takes result when out_valid&out_ready.
REQ-016 Port out_ans  output  16  captured result.
REQ-017 Port out_err  output  1  result produced by timeout (out_ans=16'h0000).
REQ-018 Port busy  output  1  high in any state except IDLE.

Function
REQ-019 FIFO: write on in_valid&in_ready, read on dispatch; in_ready=0 exactly when DEPTH entries held; simultaneous write and read on full FIFO SHALL not be accepted (in_ready already 0).
REQ-020 FSM states IDLE, ISSUE, WAIT_CLR, WAIT_DONE, HOLD.
REQ-021 IDLE->ISSUE when FIFO non-empty and (out_valid=0 or out_ready=1 this cycle); pops head into cos_x/cos_y registers.
REQ-022 ISSUE: cos_start=1 for exactly one cycle; next WAIT_CLR.
REQ-023 WAIT_CLR: wait for cos_ans_ready=0 (stale done from previous job ignored); then WAIT_DONE.
REQ-024 WAIT_DONE: on cos_ans_ready=1 capture cos_ans into out_ans, out_err=0, out_valid=1 next cycle; go IDLE.
REQ-025 Timeout counter (8 bits for default) clears on ISSUE, counts in WAIT_CLR/WAIT_DONE; at TIMEOUT load out_ans=0, out_err=1, out_valid=1, go HOLD.
REQ-026 HOLD: cos_start held 0 until cos_ans_ready=0, then IDLE (stray late done discarded).
REQ-027 out_valid clears on out_ready unless a capture occurs same cycle, in which case it stays 1 with new data.
REQ-028 Latency: job in empty FIFO, idle, done in k cycles after start -> out_valid at cycle k+3 after acceptance.
REQ-029 Jobs dispatched strictly in acceptance order; no job dropped or duplicated.
REQ-030 cos_x/cos_y SHALL not change between ISSUE and leaving WAIT_DONE/timeout.

Reset
REQ-031 rst=0 asynchronously: FSM IDLE, FIFO empty (pointers 0), cos_start=0, cos_x=0, cos_y=0, out_valid=0, out_ans=0, out_err=0, busy=0, timeout counter 0.
REQ-032 in_ready=1 during and after reset; reset mid-job discards FIFO contents and in-flight job.
REQ-033 Reset deassertion SHALL not produce a cos_start pulse.

Structure
REQ-034 Shared package cos_pkg: X_W=16, Y_W=8, ANS_W=16, state enumeration, job struct {x,y}.
REQ-035 One sub-module cos_job_fifo (parameterised DEPTH, 24-bit entries, full/empty flags); FSM and result register in top.

Verification
REQ-036 Single job x=16'h0400,y=8'h03, done pulse 20 cycles after start, ans=16'h3A12 -> one cos_start, out_ans=16'h3A12, out_err=0 at cycle 23.
REQ-037 Push 5 jobs back-to-back with DEPTH=4 -> in_ready drops after 4th accept, 5th accepted after first dispatch; outputs in order.
REQ-038 cos_ans_ready held high from previous job through new start -> no early capture; capture only after low-then-high.
REQ-039 cos_ans_ready never asserted -> out_valid=1, out_err=1, out_ans=0 after 255 cycles; next job dispatches normally.
REQ-040 out_ready held 0 with results pending -> no new cos_start until result consumed; out_ans stable.
REQ-041 rst pulsed low during WAIT_DONE with 3 jobs queued -> all outputs reset values immediately, FIFO empty, no cos_start after release.
